// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes, parity helper.
// Also imported by the keyboard receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle of the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_ack_err;
    logic       tx_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_ack_err, tx_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_ack_err, tx_timeout
    );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 4-flop clock filter with falling-edge detect, 2-flop data sync.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic nedge,
    output logic clk_s,
    output logic dat_s
);

    logic [3:0] r_clk_sh;
    logic [1:0] r_dat_sh;

    // Reset to the pulled-up idle level so no edge is seen out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sh <= '1;
            r_dat_sh <= '1;
        end else begin
            r_clk_sh <= {r_clk_sh[2:0], ps2_clk_in};
            r_dat_sh <= {r_dat_sh[0], ps2_dat_in};
        end
    end

    assign nedge = !r_clk_sh[0] && !r_clk_sh[1] && r_clk_sh[2] && r_clk_sh[3];
    assign clk_s = r_clk_sh[1];
    assign dat_s = r_dat_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, device-clocked frame,
// acknowledge check and watchdog, driving both lines open-drain.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_t       r_state;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_n;
    logic [INH_W-1:0] r_inh;
    logic [WD_W-1:0]  r_wd;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_done;
    logic             r_ack_err;
    logic             r_timeout;

    logic             w_nedge;
    logic             w_clk_s;
    logic             w_dat_s;
    logic [3:0]       w_n_next;
    logic             w_wd_hit;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .nedge      (w_nedge),
        .clk_s      (w_clk_s),
        .dat_s      (w_dat_s)
    );

    assign w_n_next = r_n + 4'd1;
    assign w_wd_hit = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_n       <= '0;
            r_inh     <= '0;
            r_wd      <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (bus.tx_valid) begin
                        r_data   <= bus.tx_data;
                        r_parity <= ps2_odd_parity(bus.tx_data);
                        r_inh    <= '0;
                        r_n      <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_inh == INH_W'(INHIBIT_CYCLES - 1)) begin
                        r_dat_oe <= 1'b1;
                        r_state  <= START;
                    end else begin
                        r_inh <= r_inh + INH_W'(1);
                    end
                end
                START: begin
                    r_clk_oe <= 1'b0;
                    r_wd     <= '0;
                    r_state  <= SEND;
                end
                SEND: begin
                    // Edge k presents data bit k-1; edge 9 parity; edge 10 releases for the stop bit.
                    if (w_nedge) begin
                        r_wd <= '0;
                        r_n  <= w_n_next;
                        case (w_n_next)
                            4'd9:    r_dat_oe <= ~r_parity;
                            4'd10: begin
                                r_dat_oe <= 1'b0;
                                r_state  <= ACK;
                            end
                            default: r_dat_oe <= ~r_data[r_n[2:0]];
                        endcase
                    end else if (w_wd_hit) begin
                        r_clk_oe  <= 1'b0;
                        r_dat_oe  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ACK: begin
                    if (w_nedge) begin
                        r_wd <= '0;
                        r_n  <= w_n_next;
                        if (w_dat_s) begin
                            r_ack_err <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= WAIT_IDLE;
                        end
                    end else if (w_wd_hit) begin
                        r_clk_oe  <= 1'b0;
                        r_dat_oe  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (w_clk_s && w_dat_s) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_wd_hit) begin
                        r_clk_oe  <= 1'b0;
                        r_dat_oe  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe     = r_clk_oe;
    assign ps2_dat_oe     = r_dat_oe;
    assign bus.tx_ready   = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.tx_done    = r_done;
    assign bus.tx_ack_err = r_ack_err;
    assign bus.tx_timeout = r_timeout;

endmodule
